instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Builds 16-bit LC3 ALU instruction words (ADD, AND, NOT, MUL, SL, SR) from
//  ALU-op requests. Opcode and sub-op bits match what the control decoder expects.
//  Sits between the test/program generator and instruction memory or IR load.
//  Buffers encoded words in a FIFO. Valid/ready handshake on both sides.
// PARAMETERS
//  DEPTH      4   FIFO entries (power of two, >=2)
//  CNT_W      3   width of LEVEL output (log2(DEPTH)+1)
// PORTS
//  CLK          in   1   rising-edge clock
//  RST_N        in   1   asynchronous, active-low reset
//  REQ_VALID    in   1   request present
//  REQ_READY    out  1   request accepted this cycle when REQ_VALID&REQ_READY
//  REQ_OP       in   4   0000 ADD,0001 AND,0100 NOT,0101 MUL,0110 SL,0111 SR
//  REQ_IMM      in   1   immediate form (ADD/AND imm5, MUL imm3)
//  REQ_DR       in   3   destination register
//  REQ_SR1      in   3   source register 1
//  REQ_SR2      in   3   source register 2 (ignored when REQ_IMM=1)
//  REQ_IMMVAL   in   5   immediate; [4:0] for ADD/AND, [2:0] for MUL
//  INSTR_VALID  out  1   FIFO head valid
//  INSTR_READY  in   1   consumer takes head when INSTR_VALID&INSTR_READY
//  INSTR        out  16  encoded instruction at FIFO head
//  LEVEL        out  CNT_W  FIFO occupancy
//  ERR          out  1   one-cycle pulse: illegal request consumed
//  ERR_COUNT    out  8   saturating count of illegal requests
// BEHAVIOUR
//  Reset (RST_N=0, async): FIFO empty, LEVEL=0, INSTR_VALID=0, INSTR=16'h0000,
//   ERR=0, ERR_COUNT=0. REQ_READY=0 while in reset, 1 on the first cycle after.
//   Reset mid-transfer discards all buffered words.
//  Encoding (combinational, written on accept):
//   ADD/AND reg: {op4,DR,SR1,1'b0,2'b00,SR2}; op4=0001 ADD, 0101 AND
//   ADD/AND imm: {op4,DR,SR1,1'b1,IMMVAL[4:0]}
//   NOT:         {4'b1001,DR,SR1,6'b111111} (REQ_IMM ignored)
//   MUL reg:     {4'b1101,DR,SR1,3'b000,SR2}
//   MUL imm:     {4'b1101,DR,SR1,3'b100,IMMVAL[2:0]}
//   SL/SR reg:   {4'b1101,DR,SR1,3'b010 SL / 3'b001 SR,SR2}
//  Illegal: any other REQ_OP, or SL/SR with REQ_IMM=1. The request is still
//   accepted (handshake completes) but is not written to the FIFO. ERR=1 the
//   next cycle. ERR_COUNT+=1, saturating at 8'hFF.
//  REQ_READY = (LEVEL != DEPTH) and registered. It does not depend on
//   INSTR_READY, so no combinational path runs from output to input.
//  INSTR/INSTR_VALID come from registers. An accept into an empty FIFO shows
//   INSTR_VALID=1 on the next cycle (latency 1).
//  INSTR holds its value while INSTR_VALID&!INSTR_READY.
//  Push and pop in the same cycle: LEVEL unchanged, order preserved.
//  Pop at LEVEL=1 with no push: INSTR_VALID=0 the next cycle. INSTR keeps its
//   last value.
//  Full: REQ_READY=0. A pop while full raises REQ_READY the next cycle.
//  Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//  LEVEL is always between 0 and DEPTH.
// TESTING
//  T1 ADD DR=1,SR1=2,SR2=3 reg, INSTR_READY=1 -> INSTR=16'h1283 one cycle later
//  T2 ADD imm DR=1,SR1=2,IMMVAL=5'h1F -> 16'h12BF; NOT DR=3,SR1=4 -> 16'h973F
//  T3 MUL imm DR=0,SR1=1,IMMVAL=5 -> 16'hD065; SR DR=2,SR1=2,SR2=7 -> 16'hD48F;
//     SL DR=5,SR1=6,SR2=1 -> 16'hDB91
//  T4 INSTR_READY=0, push 5 with DEPTH=4 -> 4 accepted, REQ_READY=0, LEVEL=4;
//     release -> words drain in order, REQ_READY back to 1
//  T5 REQ_OP=4'b0011, then SL with REQ_IMM=1 -> ERR pulses twice,
//     ERR_COUNT=2, LEVEL unchanged
//  T6 LEVEL=2, assert RST_N=0 mid-stream -> INSTR_VALID=0 and LEVEL=0
//     immediately (async); first request after release encodes correctly

Source files
------------

// File: rtl/instr_encoder_if.sv
// ----------------------------------------------------------------------------
// instr_encoder_if
//   Bundles the request side and instruction side handshakes of the
//   instr_encoder block.
//
//   Request channel (producer -> encoder):
//     req_valid, req_op[3:0], req_imm, req_dr[2:0], req_sr1[2:0],
//     req_sr2[2:0], req_immval[4:0]; req_ready flows back.
//   Instruction channel (encoder -> consumer):
//     instr_valid, instr[15:0]; instr_ready flows back.
//   Status (encoder -> observer):
//     level[CNT_W-1:0], err, err_count[7:0]
//
//   Modports:
//     master - the request producer / instruction consumer side
//     slave  - the encoder itself
// ----------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int CNT_W = 3
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic             req_imm;
    logic [2:0]       req_dr;
    logic [2:0]       req_sr1;
    logic [2:0]       req_sr2;
    logic [4:0]       req_immval;

    logic             instr_valid;
    logic             instr_ready;
    logic [15:0]      instr;

    logic [CNT_W-1:0] level;
    logic             err;
    logic [7:0]       err_count;

    modport master (
        output req_valid, req_op, req_imm, req_dr, req_sr1, req_sr2, req_immval,
        input  req_ready,
        input  instr_valid, instr,
        output instr_ready,
        input  level, err, err_count
    );

    modport slave (
        input  req_valid, req_op, req_imm, req_dr, req_sr1, req_sr2, req_immval,
        output req_ready,
        output instr_valid, instr,
        input  instr_ready,
        output level, err, err_count
    );
endinterface

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//   Turns ALU-op requests into 16-bit LC3 ALU instruction words (ADD, AND,
//   NOT, MUL, SL, SR) and buffers them in a DEPTH-entry FIFO.
//
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous, active-low reset
//     bus    - instr_encoder_if.slave: request handshake in, instruction
//              handshake out, plus level / err / err_count status.
//
//   Illegal requests (unknown op, or SL/SR with the immediate flag) are
//   accepted but dropped; they raise err for one cycle and bump a saturating
//   counter. All outputs are driven straight from flops, so there is no
//   combinational path from instr_ready to req_ready.
// ----------------------------------------------------------------------------
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_encoder_if.slave        bus
);
    localparam int PTR_W = $clog2(DEPTH);

    // Request op codes as seen on req_op.
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_SL  = 4'b0110;
    localparam logic [3:0] OP_SR  = 4'b0111;

    logic [15:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] head_idx;
    logic [CNT_W-1:0] level_q, level_d;
    logic [15:0]      instr_q, instr_d;
    logic             instr_valid_q, instr_valid_d;
    logic             req_ready_q, req_ready_d;
    logic             err_q, err_d;
    logic [7:0]       err_count_q, err_count_d;

    logic             legal;
    logic [15:0]      enc_word;
    logic             accept;
    logic             push;
    logic             pop;

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        legal    = 1'b1;
        enc_word = 16'h0000;
        unique case (bus.req_op)
            OP_ADD: enc_word = bus.req_imm
                ? {4'b0001, bus.req_dr, bus.req_sr1, 1'b1, bus.req_immval}
                : {4'b0001, bus.req_dr, bus.req_sr1, 3'b000, bus.req_sr2};
            OP_AND: enc_word = bus.req_imm
                ? {4'b0101, bus.req_dr, bus.req_sr1, 1'b1, bus.req_immval}
                : {4'b0101, bus.req_dr, bus.req_sr1, 3'b000, bus.req_sr2};
            OP_NOT: enc_word = {4'b1001, bus.req_dr, bus.req_sr1, 6'b111111};
            OP_MUL: enc_word = bus.req_imm
                ? {4'b1101, bus.req_dr, bus.req_sr1, 3'b100, bus.req_immval[2:0]}
                : {4'b1101, bus.req_dr, bus.req_sr1, 3'b000, bus.req_sr2};
            OP_SL: begin
                legal    = ~bus.req_imm;
                enc_word = {4'b1101, bus.req_dr, bus.req_sr1, 3'b010, bus.req_sr2};
            end
            OP_SR: begin
                legal    = ~bus.req_imm;
                enc_word = {4'b1101, bus.req_dr, bus.req_sr1, 3'b001, bus.req_sr2};
            end
            default: legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO control and next-state
    // ------------------------------------------------------------------
    always_comb begin
        accept = bus.req_valid & req_ready_q;
        push   = accept & legal;
        pop    = instr_valid_q & bus.instr_ready;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + CNT_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - CNT_W'(1);
        end

        // The head register is preloaded with whatever will sit at the head
        // after this cycle. When that slot is being written right now (FIFO
        // empty, or draining its last word while a new one arrives) the
        // memory does not hold it yet, so bypass the encoder output.
        head_idx = rd_ptr_d;
        instr_d  = instr_q;
        if (level_d != '0) begin
            instr_d = (push && head_idx == wr_ptr_q) ? enc_word : mem_q[head_idx];
        end

        instr_valid_d = (level_d != '0);
        req_ready_d   = (level_d != CNT_W'(DEPTH));

        err_d       = accept & ~legal;
        err_count_d = (err_d && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            instr_q       <= 16'h0000;
            instr_valid_q <= 1'b0;
            req_ready_q   <= 1'b0;
            err_q         <= 1'b0;
            err_count_q   <= 8'h00;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            req_ready_q   <= req_ready_d;
            err_q         <= err_d;
            err_count_q   <= err_count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // level already mark every slot empty, so its contents are never read
    // before being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.level       = level_q;
    assign bus.err         = err_q;
    assign bus.err_count   = err_count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder
//   Directed and randomized checks for instr_encoder. A queue-based reference
//   model encodes requests with plain arithmetic on field weights and tracks
//   occupancy, head word, ready, error pulse and saturating error count.
// ----------------------------------------------------------------------------
module tb_instr_encoder;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic clk;
    logic rst_n;

    instr_encoder_if #(.CNT_W(CNT_W)) bus ();

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int   m_q[$];
    int   m_instr;
    bit   m_ready;
    bit   m_err;
    int   m_errcnt;
    bit   last_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Encoding built from field weights: opcode<<12, DR<<9, SR1<<6, low 6 bits.
    function automatic int ref_enc(input int op, input bit imm, input int dr,
                                   input int sr1, input int sr2, input int iv,
                                   output bit legal);
        int base;
        int w;
        base  = dr * 512 + sr1 * 64;
        legal = 1'b1;
        w     = 0;
        case (op)
            0: w = 1 * 4096 + base + (imm ? 32 + iv : sr2);
            1: w = 5 * 4096 + base + (imm ? 32 + iv : sr2);
            4: w = 9 * 4096 + base + 63;
            5: w = 13 * 4096 + base + (imm ? 32 + (iv % 8) : sr2);
            6: begin legal = !imm; w = 13 * 4096 + base + 16 + sr2; end
            7: begin legal = !imm; w = 13 * 4096 + base + 8 + sr2; end
            default: legal = 1'b0;
        endcase
        return w;
    endfunction

    task automatic set_req(input int op, input bit imm, input int dr, input int sr1,
                           input int sr2, input int iv);
        bus.req_valid  = 1'b1;
        bus.req_op     = 4'(op);
        bus.req_imm    = imm;
        bus.req_dr     = 3'(dr);
        bus.req_sr1    = 3'(sr1);
        bus.req_sr2    = 3'(sr2);
        bus.req_immval = 5'(iv);
    endtask

    // Advance one clock, update the model, compare every output.
    task automatic tick(input string ph);
        bit acc;
        bit pop;
        bit legal;
        int w;
        acc = bus.req_valid && m_ready;
        pop = (m_q.size() != 0) && bus.instr_ready;
        w   = ref_enc(int'(bus.req_op), bus.req_imm, int'(bus.req_dr), int'(bus.req_sr1),
                      int'(bus.req_sr2), int'(bus.req_immval), legal);
        @(posedge clk);
        #1;
        if (pop) void'(m_q.pop_front());
        if (acc && legal) m_q.push_back(w);
        m_err = acc && !legal;
        if (m_err && m_errcnt != 255) m_errcnt++;
        if (m_q.size() != 0) m_instr = m_q[0];
        m_ready  = (m_q.size() != DEPTH);
        last_acc = acc;
        check({ph, "/valid"},  32'(bus.instr_valid), 32'(m_q.size() != 0));
        check({ph, "/instr"},  32'(bus.instr),       32'(m_instr));
        check({ph, "/level"},  32'(bus.level),       32'(m_q.size()));
        check({ph, "/ready"},  32'(bus.req_ready),   32'(m_ready));
        check({ph, "/err"},    32'(bus.err),         32'(m_err));
        check({ph, "/errcnt"}, 32'(bus.err_count),   32'(m_errcnt));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_instr  = 0;
        m_ready  = 1'b0;
        m_err    = 1'b0;
        m_errcnt = 0;
    endtask

    initial begin
        int ops[10];
        bit legal;
        int w;
        int lvl_before;
        ops = '{0, 1, 4, 5, 6, 7, 0, 5, 3, 15};

        rst_n           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_op      = 4'h0;
        bus.req_imm     = 1'b0;
        bus.req_dr      = 3'h0;
        bus.req_sr1     = 3'h0;
        bus.req_sr2     = 3'h0;
        bus.req_immval  = 5'h00;
        bus.instr_ready = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst/valid",  32'(bus.instr_valid), 32'h0);
        check("rst/instr",  32'(bus.instr),       32'h0);
        check("rst/level",  32'(bus.level),       32'h0);
        check("rst/ready",  32'(bus.req_ready),   32'h0);
        check("rst/err",    32'(bus.err),         32'h0);
        check("rst/errcnt", 32'(bus.err_count),   32'h0);
        rst_n = 1'b1;
        tick("rel");
        check("rel/ready1", 32'(bus.req_ready), 32'h1);

        // T1: ADD reg
        bus.instr_ready = 1'b1;
        set_req(0, 0, 1, 2, 3, 0);
        tick("t1");
        check("t1/word", 32'(bus.instr), 32'h1283);
        bus.req_valid = 1'b0;
        tick("t1b");

        // T2: ADD imm then NOT
        set_req(0, 1, 1, 2, 0, 5'h1F);
        tick("t2a");
        check("t2a/word", 32'(bus.instr), 32'h12BF);
        set_req(4, 1, 3, 4, 5, 7);
        tick("t2b");
        check("t2b/word", 32'(bus.instr), 32'h973F);

        // T3: MUL imm, SR, SL back to back
        set_req(5, 1, 0, 1, 0, 5);
        tick("t3a");
        check("t3a/word", 32'(bus.instr), 32'hD065);
        set_req(7, 0, 2, 2, 7, 0);
        tick("t3b");
        check("t3b/word", 32'(bus.instr), 32'hD48F);
        set_req(6, 0, 5, 6, 1, 0);
        tick("t3c");
        check("t3c/word", 32'(bus.instr), 32'hDB91);
        bus.req_valid = 1'b0;
        tick("t3d");

        // T4: fill with consumer stalled, fifth request blocked, then drain
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(1, i[0], i, 7 - i, i + 1, 16 + i);
            tick("t4fill");
        end
        check("t4/level_full", 32'(bus.level),     32'd4);
        check("t4/ready_full", 32'(bus.req_ready), 32'h0);
        set_req(5, 0, 7, 7, 7, 0);
        tick("t4blk1");
        check("t4/blocked", 32'(last_acc), 32'h0);
        tick("t4blk2");
        bus.instr_ready = 1'b1;
        tick("t4pop");
        check("t4/ready_back", 32'(bus.req_ready), 32'h1);
        for (int i = 0; i < 12 && !last_acc; i++) tick("t4wait");
        check("t4/fifth_acc", 32'(last_acc), 32'h1);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 10 && m_q.size() != 0; i++) tick("t4drain");
        tick("t4drain");
        check("t4/empty", 32'(bus.level), 32'h0);

        // T5: two illegal requests, FIFO untouched
        bus.instr_ready = 1'b0;
        set_req(0, 0, 1, 1, 1, 0);
        tick("t5pre");
        lvl_before = int'(bus.level);
        set_req(3, 0, 1, 1, 1, 0);
        tick("t5a");
        check("t5a/errpulse", 32'(bus.err), 32'h1);
        set_req(6, 1, 1, 1, 1, 0);
        tick("t5b");
        check("t5b/errpulse", 32'(bus.err), 32'h1);
        bus.req_valid = 1'b0;
        tick("t5c");
        check("t5/errcnt2",  32'(bus.err_count), 32'd2);
        check("t5/level_eq", 32'(bus.level),     32'(lvl_before));

        // T6: async reset with two words buffered
        set_req(1, 0, 2, 3, 4, 0);
        tick("t6fill");
        bus.req_valid = 1'b0;
        tick("t6hold");
        check("t6/level2", 32'(bus.level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6/valid0", 32'(bus.instr_valid), 32'h0);
        check("t6/level0", 32'(bus.level),       32'h0);
        check("t6/ready0", 32'(bus.req_ready),   32'h0);
        check("t6/err0",   32'(bus.err_count),   32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.instr_ready = 1'b1;
        tick("t6rel");
        set_req(0, 0, 1, 2, 3, 0);
        tick("t6first");
        check("t6/word", 32'(bus.instr), 32'h1283);
        bus.req_valid = 1'b0;
        tick("t6idle");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.req_valid   = ($urandom_range(0, 3) != 0);
            bus.req_op      = 4'(ops[$urandom_range(0, 9)]);
            bus.req_imm     = 1'($urandom);
            bus.req_dr      = 3'($urandom);
            bus.req_sr1     = 3'($urandom);
            bus.req_sr2     = 3'($urandom);
            bus.req_immval  = 5'($urandom);
            bus.instr_ready = ($urandom_range(0, 2) != 0);
            tick("rnd");
        end

        // Error counter saturation
        bus.instr_ready = 1'b1;
        set_req(9, 0, 0, 0, 0, 0);
        for (int i = 0; i < 260; i++) tick("sat");
        check("sat/errcnt", 32'(bus.err_count), 32'hFF);
        bus.req_valid = 1'b0;
        tick("sat_end");
        w = ref_enc(9, 0, 0, 0, 0, 0, legal);
        check("sat/illegal", 32'(legal), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
